// File: rtl/if_pc_unit.sv
// if_pc_unit: fetch PC generator with in-flight address tracking, response buffer and redirect handling
module if_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        stall_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_gnt_i,
   input  logic        inst_rvalid_i,
   input  logic [31:0] inst_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(2 * DEPTH + 2);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEP = CW'(DEPTH);
   localparam logic [CW-1:0] CAP = CW'(2 * DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   if_q [DEPTH];
   logic [PW-1:0] if_wp, if_rp;
   logic [CW-1:0] if_cnt;
   logic [31:0]   buf_pc [DEPTH];
   logic [31:0]   buf_inst [DEPTH];
   logic [PW-1:0] buf_wp, buf_rp;
   logic [CW-1:0] buf_cnt;
   logic [CW-1:0] discard_cnt;
   logic          redirect, fire, take, drop, pop;
   logic [31:0]   target;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == LAST ? '0 : p + PW'(1);
   endfunction

   // request gating, response classification and buffer-head presentation
   always_comb begin
      redirect     = flush_i | branch_flag_i;
      target       = flush_i ? new_pc_i : branch_target_i;
      inst_req_o   = !rst && !redirect && (if_cnt + buf_cnt < DEP) && (if_cnt + discard_cnt < CAP);
      inst_addr_o  = fetch_pc;
      fire         = inst_req_o && inst_gnt_i;
      take         = inst_rvalid_i && discard_cnt == '0 && if_cnt != '0;
      drop         = inst_rvalid_i && discard_cnt != '0;
      inst_valid_o = !rst && buf_cnt != '0;
      pop          = inst_valid_o && !stall_i;
      pc_o         = inst_valid_o ? buf_pc[buf_rp] : '0;
      inst_o       = inst_valid_o ? buf_inst[buf_rp] : '0;
   end

   // fetch PC, queue pointers/counts and stale-response discard counter
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         if_wp       <= '0;
         if_rp       <= '0;
         if_cnt      <= '0;
         buf_wp      <= '0;
         buf_rp      <= '0;
         buf_cnt     <= '0;
         discard_cnt <= '0;
      end else if (redirect) begin
         fetch_pc    <= {target[31:2], 2'b00};
         if_wp       <= '0;
         if_rp       <= '0;
         if_cnt      <= '0;
         buf_wp      <= '0;
         buf_rp      <= '0;
         buf_cnt     <= '0;
         discard_cnt <= if_cnt + CW'(fire) - CW'(take) + discard_cnt - CW'(drop);
      end else begin
         if (fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            if_wp    <= nxt(if_wp);
         end
         if (take) begin
            if_rp  <= nxt(if_rp);
            buf_wp <= nxt(buf_wp);
         end
         if (pop) buf_rp <= nxt(buf_rp);
         if (drop) discard_cnt <= discard_cnt - CW'(1);
         if_cnt  <= if_cnt + CW'(fire) - CW'(take);
         buf_cnt <= buf_cnt + CW'(take) - CW'(pop);
      end
   end

   // queue payload storage; validity is tracked solely by the counters above
   always_ff @(posedge clk) begin
      if (fire) if_q[if_wp] <= fetch_pc;
      if (take) begin
         buf_pc[buf_wp]   <= if_q[if_rp];
         buf_inst[buf_wp] <= inst_rdata_i;
      end
   end
endmodule

// File: tb/tb_if_pc_unit.sv
// tb_if_pc_unit: scoreboard bench for if_pc_unit with a 1-cycle-latency memory model
module tb_if_pc_unit;
   logic        clk = 0, rst = 1;
   logic        flush_i = 0, branch_flag_i = 0, stall_i = 0;
   logic [31:0] new_pc_i = '0, branch_target_i = '0;
   logic        inst_req_o, inst_gnt_i = 1, inst_rvalid_i = 0;
   logic [31:0] inst_addr_o, inst_rdata_i = '0;
   logic        inst_valid_o;
   logic [31:0] pc_o, inst_o;

   int          checks = 0, errors = 0;
   logic [31:0] mq[$];
   logic [31:0] exp_pc[$];
   logic [31:0] exp_addr[$];
   logic        hold = 0, bad200 = 0;
   logic        obs_req, obs_valid;
   logic [31:0] obs_addr, obs_pc, obs_inst;

   if_pc_unit dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .new_pc_i(new_pc_i),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i), .stall_i(stall_i),
      .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o), .inst_gnt_i(inst_gnt_i),
      .inst_rvalid_i(inst_rvalid_i), .inst_rdata_i(inst_rdata_i),
      .inst_valid_o(inst_valid_o), .pc_o(pc_o), .inst_o(inst_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      logic [31:0] e;
      if (!hold && mq.size() > 0) begin
         inst_rvalid_i = 1;
         inst_rdata_i  = memw(mq.pop_front());
      end else begin
         inst_rvalid_i = 0;
         inst_rdata_i  = '0;
      end
      #1;
      obs_req = inst_req_o; obs_addr = inst_addr_o; obs_valid = inst_valid_o;
      obs_pc = pc_o; obs_inst = inst_o;
      if (obs_valid === 1'b1 && !stall_i) begin
         if (exp_pc.size() == 0) chk("sb_underflow", 32'(exp_pc.size()), 32'd1);
         else begin
            e = exp_pc.pop_front();
            chk("pc", obs_pc, e);
            chk("inst", obs_inst, memw(e));
         end
      end
      if (obs_req === 1'b1 && inst_gnt_i) begin
         if (obs_addr == 32'h200) bad200 = 1;
         if (exp_addr.size() > 0) chk("fetch_addr", obs_addr, exp_addr.pop_front());
      end
      @(posedge clk);
      if (obs_req === 1'b1 && inst_gnt_i) mq.push_back(obs_addr);
      if (rst) mq.delete();
      @(negedge clk);
   endtask

   task automatic redir(input logic f, input logic [31:0] np, input logic b, input logic [31:0] bt);
      flush_i = f; new_pc_i = np; branch_flag_i = b; branch_target_i = bt;
      step();
      flush_i = 0; branch_flag_i = 0;
   endtask

   task automatic drain(input string tag);
      stall_i = 0;
      for (int c = 0; c < 80 && exp_pc.size() > 0; c++) step();
      chk(tag, 32'(exp_pc.size()), 32'd0);
      stall_i = 1;
   endtask

   initial begin
      int fv;
      @(negedge clk);
      step();
      step();
      chk("rst_req", 32'(obs_req), 0);
      chk("rst_valid", 32'(obs_valid), 0);
      chk("rst_pc", obs_pc, 0);
      chk("rst_inst", obs_inst, 0);
      chk("rst_addr", obs_addr, 0);

      rst = 0;
      exp_addr = '{32'h0, 32'h4, 32'h8};
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
      fv = 0;
      for (int c = 1; c <= 60 && exp_pc.size() > 0; c++) begin
         step();
         if (fv == 0 && obs_valid) fv = c;
      end
      chk("first_valid_cycle", 32'(fv), 3);
      chk("t1_drain", 32'(exp_pc.size()), 0);
      chk("t1_addr_left", 32'(exp_addr.size()), 0);

      stall_i = 1;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c > 2) begin
            chk("stall_req", 32'(obs_req), 0);
            chk("stall_valid", 32'(obs_valid), 1);
            chk("stall_pc", obs_pc, 32'h18);
         end
      end
      for (int a = 32'h18; a <= 32'h30; a += 4) exp_pc.push_back(32'(a));
      drain("t2_drain");

      redir(0, '0, 1, 32'h40);
      hold = 1;
      step();
      step();
      hold = 0;
      redir(0, '0, 1, 32'h100);
      chk("redir_req_low", 32'(obs_req), 0);
      step();
      chk("br_addr", obs_addr, 32'h100);
      chk("br_req", 32'(obs_req), 1);
      exp_pc = '{32'h100, 32'h104, 32'h108};
      drain("t3_drain");

      step();
      step();
      step();
      redir(1, 32'h0C, 1, 32'h200);
      step();
      chk("flush_valid_low", 32'(obs_valid), 0);
      chk("flush_addr", obs_addr, 32'h0C);
      exp_pc = '{32'h0C, 32'h10, 32'h14};
      drain("t4_drain");

      redir(0, '0, 1, 32'hFFFF_FFF8);
      exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
      exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      drain("t5_drain");
      chk("t5_addr_left", 32'(exp_addr.size()), 0);

      redir(0, '0, 1, 32'h103);
      step();
      chk("align_addr", obs_addr, 32'h100);
      exp_pc = '{32'h100, 32'h104};
      drain("t6_drain");

      redir(0, '0, 1, 32'h300);
      inst_gnt_i = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("nogrant_req", 32'(obs_req), 1);
         chk("nogrant_addr", obs_addr, 32'h300);
      end
      inst_gnt_i = 1;
      exp_pc = '{32'h300, 32'h304};
      drain("t7_drain");

      step();
      rst = 1;
      step();
      step();
      chk("mid_rst_req", 32'(obs_req), 0);
      chk("mid_rst_valid", 32'(obs_valid), 0);
      chk("mid_rst_pc", obs_pc, 0);
      chk("mid_rst_inst", obs_inst, 0);
      rst = 0;
      exp_addr = '{32'h0, 32'h4};
      exp_pc = '{32'h0, 32'h4, 32'h8};
      drain("t8_drain");
      chk("t8_addr_left", 32'(exp_addr.size()), 0);
      chk("never_200", 32'(bad200), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
